// File: rtl/lane_serializer_pkg.sv
// Shared types and helpers for the lane serializer.
// Parity output is enabled by the LANE_SERIALIZER_PARITY_EN macro.
package lane_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int lane_idx_w(input int lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/lane_serializer.sv
// Serializes a packed multi-lane word, one lane per cycle, valid/ready both sides.
// Optional out_parity port is built when LANE_SERIALIZER_PARITY_EN is defined.
module lane_serializer
    import lane_serializer_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0][LANE_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANE_W-1:0]            out_data,
    output logic                         out_last
`ifdef LANE_SERIALIZER_PARITY_EN
    ,
    output logic                         out_parity
`endif
);

    localparam int IW = lane_idx_w(LANES);
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    state_t                         state_q, state_d;
    logic   [IW-1:0]                idx_q, idx_d;
    logic   [LANES-1:0][LANE_W-1:0] buf_q, buf_d;
    logic                           at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    assign at_last = (idx_q == LAST);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        in_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_d   = in_data;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    if (!at_last) begin
                        idx_d = idx_q + IW'(1);
                    end else begin
                        // last lane leaving: a waiting word is taken with no bubble
                        in_ready = 1'b1;
                        if (in_valid) begin
                            buf_d = in_data;
                            idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
        endcase
        if (rst) in_ready = 1'b0;
    end

    assign out_valid = (state_q == SHIFT);
    assign out_data  = buf_q[idx_q];
    assign out_last  = out_valid & at_last;

`ifdef LANE_SERIALIZER_PARITY_EN
    assign out_parity = out_valid & (^buf_q[idx_q]);
`endif

endmodule
